elastic_pipeline_reg: RTL and testbench

ELASTIC_PIPELINE_REG -- requirements
Module: elastic_pipeline_reg

---
 rtl/elastic_pipeline_reg.sv | 113 +++++++++++
 tb/tb_elastic_pipeline_reg.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipeline_reg.sv
// Elastic pipeline register: DEPTH cascaded main+skid stages with registered ready.
// Optional synchronous flush port enabled by defining PIPE_FLUSH_EN.
`timescale 1ns/1ps

module elastic_pipeline_reg #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PIPE_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } stage_state_t;

  logic             flush_i;
  logic [DEPTH:0]   vld_chain;
  logic [DEPTH:0]   rdy_chain;
  logic [WIDTH-1:0] data_chain [DEPTH+1];

`ifdef PIPE_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign vld_chain[0]     = in_valid;
  assign data_chain[0]    = in_data;
  assign rdy_chain[DEPTH] = out_ready;
  assign in_ready         = rdy_chain[0];
  assign out_valid        = vld_chain[DEPTH];
  assign out_data         = data_chain[DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    stage_state_t     state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             ready_q;
    logic             push, pop;

    assign push = vld_chain[i] & ready_q;
    assign pop  = (state_q != S_EMPTY) & rdy_chain[i+1];

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
        S_EMPTY: begin
          if (push) begin
            main_d  = data_chain[i];
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            main_d = data_chain[i];
          end else if (push) begin
            skid_d  = data_chain[i];
            state_d = S_TWO;
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
      // Flush drops every held beat and any same-edge push, but leaves data untouched.
      if (flush_i) begin
        state_d = S_EMPTY;
        main_d  = main_q;
        skid_d  = skid_q;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        state_q <= S_EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
        ready_q <= 1'b1;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        ready_q <= (state_d != S_TWO);
      end
    end

    assign vld_chain[i+1]  = (state_q != S_EMPTY);
    assign data_chain[i+1] = main_q;
    assign rdy_chain[i]    = ready_q;
  end

endmodule

// File: tb/tb_elastic_pipeline_reg.sv
// Directed/random bench for elastic_pipeline_reg; five instances with DEPTH 1,2,3,4,16.
// Flush checks are compiled in when PIPE_FLUSH_EN is defined.
`timescale 1ns/1ps

module tb_elastic_pipeline_reg;

  localparam int unsigned W  = 128;
  localparam int unsigned NI = 5;

  logic         clk = 1'b0;
  logic         rst_n [NI];
  logic         iv    [NI];
  logic [W-1:0] id    [NI];
  logic         irdy  [NI];
  logic [W-1:0] od    [NI];
  logic         ov    [NI];
  logic         ordy  [NI];
`ifdef PIPE_FLUSH_EN
  logic         fl    [NI];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : (g == 3) ? 4 : 16;
    elastic_pipeline_reg #(.WIDTH(W), .DEPTH(D)) u_dut (
      .clk      (clk),
      .reset_n  (rst_n[g]),
      .in_data  (id[g]),
      .in_valid (iv[g]),
      .in_ready (irdy[g]),
      .out_data (od[g]),
      .out_valid(ov[g]),
      .out_ready(ordy[g])
`ifdef PIPE_FLUSH_EN
      ,
      .flush    (fl[g])
`endif
    );
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Random traffic against a queue scoreboard; pops are modelled before pushes.
  task automatic rand_run(input int k, input int nbeats, input string tag);
    logic [W-1:0] sb [$];
    logic [W-1:0] exp;
    int sent = 0;
    int rcvd = 0;
    int cyc  = 0;
    while (rcvd < nbeats && cyc < 20000) begin
      @(posedge clk); #1;
      iv[k]   = (sent < nbeats) ? 1'($urandom_range(0, 1)) : 1'b0;
      id[k]   = {$urandom, $urandom, $urandom, $urandom};
      ordy[k] = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (ov[k] && ordy[k]) begin
        if (sb.size() == 0) begin
          check({tag, "_extra"}, od[k], '0);
          check({tag, "_extra_valid"}, W'(ov[k]), '0);
        end else begin
          exp = sb.pop_front();
          check(tag, od[k], exp);
        end
        rcvd++;
      end
      if (iv[k] && irdy[k]) begin
        sb.push_back(id[k]);
        sent++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    iv[k]   = 1'b0;
    ordy[k] = 1'b0;
    check({tag, "_count"}, W'(rcvd), W'(nbeats));
    check({tag, "_left"}, W'(sb.size()), '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n, gaps, lowrdy, rcv, seen;
    bit got5;

    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0; iv[k] = 1'b0; id[k] = '0; ordy[k] = 1'b0;
`ifdef PIPE_FLUSH_EN
      fl[k] = 1'b0;
`endif
    end
    // Beat offered during reset must not be taken.
    iv[0] = 1'b1;
    id[0] = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ov",      W'(ov[0]),   '0);
    check("rst_od",      od[0],       '0);
    check("rst_irdy",    W'(irdy[0]), W'(1));
    check("rst_ov_d16",  W'(ov[4]),   '0);
    check("rst_irdy_d16",W'(irdy[4]), W'(1));
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
    iv[0] = 1'b0;

    // Mid-operation reset on DEPTH=1
    iv[0] = 1'b1; id[0] = W'(128'h55);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(negedge clk);
    check("mid_ov",  W'(ov[0]), W'(1));
    check("mid_od",  od[0],     W'(128'h55));
    @(posedge clk); #1;
    rst_n[0] = 1'b0; iv[0] = 1'b1; id[0] = '1;
    @(posedge clk); #1;
    rst_n[0] = 1'b1; iv[0] = 1'b0;
    @(negedge clk);
    check("mid_rst_ov",   W'(ov[0]),   '0);
    check("mid_rst_od",   od[0],       '0);
    check("mid_rst_irdy", W'(irdy[0]), W'(1));

    // Latency on DEPTH=3: captured on first edge, visible after the third edge
    @(posedge clk); #1;
    ordy[2] = 1'b1; iv[2] = 1'b1; id[2] = W'(128'hFF);
    @(negedge clk);
    check("lat_irdy", W'(irdy[2]), W'(1));
    @(posedge clk); #1;
    iv[2] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("lat_ov", W'(ov[2]), W'(j == 2));
      if (j < 2) @(posedge clk);
    end
    check("lat_od", od[2], W'(128'hFF));
    @(posedge clk); #1;
    ordy[2] = 1'b0;

    // Backpressure on DEPTH=2: four beats fill it, fifth is held off
    for (int v = 1; v <= 4; v++) begin
      iv[1] = 1'b1; id[1] = W'(v);
      @(negedge clk);
      check("bp_accept", W'(irdy[1]), W'(1));
      @(posedge clk); #1;
    end
    id[1] = W'(5);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("bp_full", W'(irdy[1]), '0);
      check("bp_ov",   W'(ov[1]),   W'(1));
      check("bp_hold", od[1],       W'(1));
      @(posedge clk); #1;
    end
    ordy[1] = 1'b1;
    n = 0; got5 = 1'b0;
    for (int c = 0; c < 20 && n < 5; c++) begin
      @(negedge clk);
      if (iv[1] && irdy[1]) got5 = 1'b1;
      if (ov[1] && ordy[1]) begin
        check("bp_out", od[1], W'(n + 1));
        n++;
      end
      @(posedge clk); #1;
      if (got5) iv[1] = 1'b0;
    end
    iv[1] = 1'b0; ordy[1] = 1'b0;
    check("bp_count", W'(n), W'(5));

    // Streaming on DEPTH=4: beat c visible in cycle c+4, no bubbles
    ordy[3] = 1'b1;
    gaps = 0; lowrdy = 0; rcv = 0;
    for (int c = 0; c < 104; c++) begin
      iv[3] = (c < 100);
      id[3] = W'(c);
      @(negedge clk);
      if (c < 100 && !irdy[3]) lowrdy++;
      if (c >= 4) begin
        if (!ov[3]) gaps++;
        else begin
          check("stream_data", od[3], W'(c - 4));
          rcv++;
        end
      end
      @(posedge clk); #1;
    end
    iv[3] = 1'b0; ordy[3] = 1'b0;
    check("stream_irdy_low", W'(lowrdy), '0);
    check("stream_gaps",     W'(gaps),   '0);
    check("stream_count",    W'(rcv),    W'(100));

`ifdef PIPE_FLUSH_EN
    // Flush on DEPTH=2 with three beats held and a beat offered on the flush edge
    ordy[1] = 1'b0;
    for (int v = 1; v <= 3; v++) begin
      iv[1] = 1'b1; id[1] = W'(v * 17);
      @(posedge clk); #1;
    end
    fl[1] = 1'b1; iv[1] = 1'b1; id[1] = W'(128'hAA); ordy[1] = 1'b1;
    @(posedge clk); #1;
    fl[1] = 1'b0; iv[1] = 1'b0;
    @(negedge clk);
    check("flush_ov",   W'(ov[1]),   '0);
    check("flush_irdy", W'(irdy[1]), W'(1));
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ov[1]) seen++;
      @(posedge clk); #1;
    end
    check("flush_no_beat", W'(seen), '0);
    ordy[1] = 1'b0;
`endif

    rand_run(0, 1000, "rnd_d1");
    rand_run(4, 1000, "rnd_d16");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
